// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: FSM states, song ROM entry
// layout and a helper that packs a ROM entry from its fields.
package melody_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      PLAY  = 3'd2,
      GAP   = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Entry layout: [11] last, [10:9] pitch, [8:5] note, [4:0] dur
   localparam int ENTRY_W    = 12;
   localparam int LAST_BIT   = 11;
   localparam int PITCH_LSB  = 9;
   localparam int PITCH_W    = 2;
   localparam int NOTE_LSB   = 5;
   localparam int NOTE_W     = 4;
   localparam int DUR_LSB    = 0;
   localparam int DUR_W      = 5;

   localparam int SONG_DEPTH = 64;
   localparam int IDX_W      = 6;
   localparam int SEL_W      = 2;
   localparam int ADDR_W     = SEL_W + IDX_W;

   localparam logic [NOTE_W-1:0] NOTE_REST = '0;

   function automatic logic [ENTRY_W-1:0] make_entry(
      input logic               last,
      input logic [PITCH_W-1:0] pitch,
      input logic [NOTE_W-1:0]  note,
      input logic [DUR_W-1:0]   dur
   );
      return {last, pitch, note, dur};
   endfunction

endpackage

// File: rtl/melody_rom.sv
// 256x12 song ROM, four songs of 64 entries each, synchronous read with
// one cycle of latency.
//   song 0: C4 p1 d2, rest d1, G4 p2 d3 (last)
//   song 1: note 3 p1 with dur=0 (played as one tick), last
//   song 2: 64 one-tick notes cycling 1..4 at p1, no last flag anywhere
//   song 3: note 9 p1 d1, note 7 p2 d1, note 12 p3 d2 (last)
module melody_rom
   import melody_pkg::*;
(
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   output logic [ENTRY_W-1:0] data
);

   function automatic logic [ENTRY_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
      logic [SEL_W-1:0] song;
      logic [IDX_W-1:0] idx;
      logic [ENTRY_W-1:0] w;
      song = a[ADDR_W-1:IDX_W];
      idx  = a[IDX_W-1:0];
      w    = '0;
      case (song)
         2'd0: begin
            case (idx)
               6'd0:    w = make_entry(1'b0, 2'd1, 4'd1, 5'd2);
               6'd1:    w = make_entry(1'b0, 2'd0, NOTE_REST, 5'd1);
               6'd2:    w = make_entry(1'b1, 2'd2, 4'd5, 5'd3);
               default: w = '0;
            endcase
         end
         2'd1: begin
            case (idx)
               6'd0:    w = make_entry(1'b1, 2'd1, 4'd3, 5'd0);
               default: w = '0;
            endcase
         end
         2'd2: begin
            w = make_entry(1'b0, 2'd1, {2'b00, idx[1:0]} + 4'd1, 5'd1);
         end
         default: begin
            case (idx)
               6'd0:    w = make_entry(1'b0, 2'd1, 4'd9, 5'd1);
               6'd1:    w = make_entry(1'b0, 2'd2, 4'd7, 5'd1);
               6'd2:    w = make_entry(1'b1, 2'd3, 4'd12, 5'd2);
               default: w = '0;
            endcase
         end
      endcase
      return w;
   endfunction

   // Registered read: data for addr appears after the next clock edge
   always_ff @(posedge clk) begin
      data <= rom_word(addr);
   end

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: steps through a song in melody_rom and drives the tone
// generator's note/pitch inputs, with an optional silent gap after each note.
// Optional feature macro: MELODY_LOOP_EN -- when defined, a finished song
// restarts from entry 0 (done pulses on each wrap) instead of returning to IDLE.
//
// Handshake: start/stop are plain levels. start is only looked at in IDLE
// (stop wins if both are high); stop aborts from any busy state on the next
// edge without a done pulse. done is a one-cycle pulse, busy is a level.
module melody_sequencer
   import melody_pkg::*;
#(
   parameter int CLK_HZ    = 50_000_000,
   parameter int TICK_HZ   = 16,
   parameter int GAP_TICKS = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic [SEL_W-1:0]   song_sel,
   output logic [NOTE_W-1:0]  note,
   output logic [PITCH_W-1:0] pitch,
   output logic               busy,
   output logic               done
);

   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int TICK_W   = $clog2(TICK_DIV);
   localparam int GAP_W    = $clog2(GAP_TICKS + 2);
   localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(SONG_DEPTH - 1);

   state_t               state_q, state_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
   logic [DUR_W-1:0]     dur_cnt_q, dur_cnt_d;
   logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
   logic [NOTE_W-1:0]    note_q, note_d;
   logic [PITCH_W-1:0]   pitch_q, pitch_d;
   logic                 last_q, last_d;
   logic                 wrap_q, wrap_d;

   logic                 tick;
   logic                 end_chk;
   logic [DUR_W-1:0]     rom_dur;
   logic [ADDR_W-1:0]    rom_addr;
   logic [ENTRY_W-1:0]   rom_data;

   // The ROM is addressed with next-state values so the entry is ready
   // during the FETCH cycle and can be captured on the edge leaving it.
   melody_rom u_rom (
      .clk  (clk),
      .addr (rom_addr),
      .data (rom_data)
   );

   assign rom_dur = rom_data[DUR_LSB +: DUR_W];

   // State register and all counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         sel_q      <= '0;
         idx_q      <= '0;
         tick_cnt_q <= '0;
         dur_cnt_q  <= '0;
         gap_cnt_q  <= '0;
         note_q     <= '0;
         pitch_q    <= '0;
         last_q     <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         idx_q      <= idx_d;
         tick_cnt_q <= tick_cnt_d;
         dur_cnt_q  <= dur_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         note_q     <= note_d;
         pitch_q    <= pitch_d;
         last_q     <= last_d;
         wrap_q     <= wrap_d;
      end
   end

   // Next-state logic: tick generation, per-state counters, end-of-note check
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      idx_d      = idx_q;
      tick_cnt_d = tick_cnt_q;
      dur_cnt_d  = dur_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      note_d     = note_q;
      pitch_d    = pitch_q;
      last_d     = last_q;
      wrap_d     = 1'b0;
      end_chk    = 1'b0;

      tick = ((state_q == PLAY) || (state_q == GAP)) && (tick_cnt_q == TICK_MAX);
      if ((state_q == PLAY) || (state_q == GAP)) begin
         tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               sel_d   = song_sel;
               idx_d   = '0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            note_d    = rom_data[NOTE_LSB +: NOTE_W];
            pitch_d   = rom_data[PITCH_LSB +: PITCH_W];
            last_d    = rom_data[LAST_BIT];
            dur_cnt_d = (rom_dur == '0) ? DUR_W'(1) : rom_dur;
            state_d   = PLAY;
         end
         PLAY: begin
            if (tick) begin
               dur_cnt_d = dur_cnt_q - 1'b1;
               if (dur_cnt_q == DUR_W'(1)) begin
                  if (GAP_TICKS > 0) begin
                     gap_cnt_d = GAP_W'(GAP_TICKS);
                     state_d   = GAP;
                  end else begin
                     end_chk = 1'b1;
                  end
               end
            end
         end
         GAP: begin
            if (tick) begin
               gap_cnt_d = gap_cnt_q - 1'b1;
               if (gap_cnt_q == GAP_W'(1)) begin
                  end_chk = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // End-of-entry decision, taken on the same edge that leaves PLAY/GAP;
      // entry 63 ends the song even without its last flag.
      if (end_chk) begin
         if (last_q || (idx_q == IDX_LAST)) begin
`ifdef MELODY_LOOP_EN
            idx_d   = '0;
            wrap_d  = 1'b1;
            state_d = FETCH;
`else
            state_d = DONE;
`endif
         end else begin
            idx_d   = idx_q + 1'b1;
            state_d = FETCH;
         end
      end

      // Each note starts with a full tick period
      if ((state_d == FETCH) && (state_q != FETCH)) begin
         tick_cnt_d = '0;
      end

      if (stop && (state_q != IDLE)) begin
         state_d = IDLE;
         wrap_d  = 1'b0;
      end

      rom_addr = {sel_d, idx_d};
   end

   // Outputs decoded from the current state; silent everywhere except PLAY
   always_comb begin
      note  = '0;
      pitch = '0;
      if (state_q == PLAY) begin
         note  = note_q;
         pitch = pitch_q;
      end
      busy = (state_q != IDLE);
      done = (state_q == DONE) || wrap_q;
   end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with TICK_DIV=10 and GAP_TICKS=1.
// Expected per-cycle output words {busy, done, pitch, note} are built from
// the song table and the note/gap/fetch timing, then compared cycle by cycle.
module tb_melody_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stop;
   logic [1:0] song_sel;
   logic [3:0] note;
   logic [1:0] pitch;
   logic       busy;
   logic       done;

   int n_vec = 0;
   int n_bad = 0;
   logic [7:0] exp_q[$];

   melody_sequencer #(
      .CLK_HZ    (100),
      .TICK_HZ   (10),
      .GAP_TICKS (1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .song_sel (song_sel),
      .note     (note),
      .pitch    (pitch),
      .busy     (busy),
      .done     (done)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, expected finish before 500000ns");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] obs();
      return {busy, done, pitch, note};
   endfunction

   function automatic logic [7:0] ev(input logic b, input logic d,
                                     input logic [1:0] p, input logic [3:0] n);
      return {b, d, p, n};
   endfunction

   task automatic push(input int n, input logic [7:0] v);
      repeat (n) exp_q.push_back(v);
   endtask

   // song 0 from its FETCH cycle up to the end of the final gap
   task automatic push_song0();
      push(1,  ev(1, 0, 2'd0, 4'd0));   // fetch C4
      push(20, ev(1, 0, 2'd1, 4'd1));   // C4 p1, 2 ticks
      push(10, ev(1, 0, 2'd0, 4'd0));   // gap
      push(1,  ev(1, 0, 2'd0, 4'd0));   // fetch rest
      push(10, ev(1, 0, 2'd0, 4'd0));   // rest, 1 tick
      push(10, ev(1, 0, 2'd0, 4'd0));   // gap
      push(1,  ev(1, 0, 2'd0, 4'd0));   // fetch G4
      push(30, ev(1, 0, 2'd2, 4'd5));   // G4 p2, 3 ticks
      push(10, ev(1, 0, 2'd0, 4'd0));   // gap
   endtask

   // driver: compare one expected word per cycle; start drops to keep_start
   // after the first sampled cycle
   task automatic run_trace(input string tag, input logic keep_start);
      int k = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         check(tag, 32'(obs()), 32'(exp_q.pop_front()));
         if (k == 0) start = keep_start;
         k++;
      end
   endtask

   task automatic start_song(input logic [1:0] sel);
      @(negedge clk);
      song_sel = sel;
      start    = 1'b1;
   endtask

   task automatic wait_note(input string tag, input logic [3:0] n, input int budget);
      int c = 0;
      while ((note !== n) && (c < budget)) begin
         @(negedge clk);
         c++;
      end
      check(tag, 32'(note === n), 32'd1);
   endtask

   task automatic abort_song();
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b1;
      @(negedge clk);
      stop  = 1'b0;
      check("abort_idle", 32'(obs()), 32'd0);
   endtask

   initial begin
      int done_cnt;
      rst      = 1'b0;
      start    = 1'b0;
      stop     = 1'b0;
      song_sel = 2'd0;

      // asynchronous reset, checked before any clock edge
      #2 rst = 1'b1;
      #1;
      check("rst_note",  32'(note),  32'd0);
      check("rst_pitch", 32'(pitch), 32'd0);
      check("rst_busy",  32'(busy),  32'd0);
      check("rst_done",  32'(done),  32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("idle_after_rst", 32'(obs()), 32'd0);

`ifndef MELODY_LOOP_EN
      // song 0 played once, full timing
      start_song(2'd0);
      push_song0();
      push(1, ev(1, 1, 2'd0, 4'd0));    // done pulse
      push(1, ev(0, 0, 2'd0, 4'd0));    // idle
      run_trace("song0_trace", 1'b0);

      // start held high: replay right after DONE; song_sel change mid-song
      // only affects the replay
      start_song(2'd0);
      fork
         begin
            repeat (30) @(negedge clk);
            song_sel = 2'd3;
         end
      join_none
      push_song0();
      push(1,  ev(1, 1, 2'd0, 4'd0));
      push(1,  ev(0, 0, 2'd0, 4'd0));
      push(1,  ev(1, 0, 2'd0, 4'd0));   // fetch song 3 entry 0
      push(10, ev(1, 0, 2'd1, 4'd9));
      run_trace("replay_trace", 1'b1);
      abort_song();

      // dur=0 is played as one tick
      start_song(2'd1);
      push(1,  ev(1, 0, 2'd0, 4'd0));
      push(10, ev(1, 0, 2'd1, 4'd3));
      push(10, ev(1, 0, 2'd0, 4'd0));
      push(1,  ev(1, 1, 2'd0, 4'd0));
      push(1,  ev(0, 0, 2'd0, 4'd0));
      run_trace("dur0_trace", 1'b0);

      // 64 entries without a last flag: stops after index 63, one done pulse
      start_song(2'd2);
      for (int i = 0; i < 64; i++) begin
         push(1,  ev(1, 0, 2'd0, 4'd0));
         push(10, ev(1, 0, 2'd1, 4'((i % 4) + 1)));
         push(10, ev(1, 0, 2'd0, 4'd0));
      end
      push(1, ev(1, 1, 2'd0, 4'd0));
      push(2, ev(0, 0, 2'd0, 4'd0));
      run_trace("song2_trace", 1'b0);
`else
      // looping: done pulses during the refetch, busy stays high
      start_song(2'd0);
      push_song0();
      push(1,  ev(1, 1, 2'd0, 4'd0));
      push(20, ev(1, 0, 2'd1, 4'd1));
      push(10, ev(1, 0, 2'd0, 4'd0));
      run_trace("loop_trace", 1'b0);
      abort_song();
`endif

      // stop while G4 plays: idle on the next edge, no done pulse
      start_song(2'd0);
      @(negedge clk);
      start = 1'b0;
      wait_note("stop_wait_g4", 4'd5, 200);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("stop_note",  32'(note),  32'd0);
      check("stop_pitch", 32'(pitch), 32'd0);
      check("stop_busy",  32'(busy),  32'd0);
      done_cnt = (done === 1'b1) ? 1 : 0;
      repeat (60) begin
         @(negedge clk);
         if (done === 1'b1) done_cnt++;
      end
      check("stop_no_done", 32'(done_cnt), 32'd0);
      check("stop_stays_idle", 32'(busy), 32'd0);

      // async reset in the middle of a note, between clock edges
      start_song(2'd0);
      @(negedge clk);
      start = 1'b0;
      wait_note("rst_wait_c4", 4'd1, 50);
      #2 rst = 1'b1;
      #1;
      check("midrst_note",  32'(note),  32'd0);
      check("midrst_pitch", 32'(pitch), 32'd0);
      check("midrst_busy",  32'(busy),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_idle", 32'(obs()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
